dragon_spawn_sched: RTL and testbench
=====================================

// Module: dragon_spawn_sched
// PURPOSE
//  - Owns NUM_SLOTS dragon slots; sequences each through READY -> ACTIVE -> COOLDOWN.
//  - Grants at most one spawn per spawn_tick, round-robin among READY slots.
//  - Steps active dragons on frame_tick; retires them on a hit or at the screen border.
//  - Sits between the game event logic (hit vectors, tick pulses) and the VGA sprite renderer.
// PARAMETERS
//  NUM_SLOTS  4    dragon slots; power of 2, 2..8
//  COOLDOWN   100  frame_ticks spent in COOLDOWN before the slot returns to READY
//  STEP       2    pixels moved per frame_tick: x decreases, y increases
//  START_X    560  spawn x, top-left corner of the sprite
//  START_Y    60   spawn y for lane 0; lane k spawns at START_Y + 40*k, k = 0..3
// PORTS
//  clk_22       in   1              system clock
//  rst          in   1              asynchronous, active-low reset
//  frame_tick   in   1              1-cycle pulse: advance positions and cooldowns
//  spawn_tick   in   1              1-cycle pulse: request one spawn
//  hit          in   NUM_SLOTS      per-slot kill request, sampled on frame_tick
//  slot_valid   out  NUM_SLOTS      slot is ACTIVE; drives the renderer show-enable
//  slot_x       out  10*NUM_SLOTS   packed x position; slot i at bits [10i+9:10i]
//  slot_y       out  10*NUM_SLOTS   packed y position, same packing as slot_x
//  spawn_pulse  out  1              1 cycle high when a spawn is granted
//  spawn_id     out  $clog2(N)      index of the granted slot; valid while spawn_pulse is high
// BEHAVIOUR
//  - Reset: all slots READY; slot_valid = 0; all x/y = 0; spawn_pulse = 0; spawn_id = 0.
//    Reset also clears the rr pointer, lane counter and all cooldown counters.
//    Reset asserted mid-operation aborts every slot at once; no kills are reported.
//  - Spawn grant on spawn_tick, cycle t:
//    - Scan READY slots starting at the rr pointer; grant the first one found.
//    - At t+1: granted slot is ACTIVE, slot_valid = 1, x = START_X, y = START_Y + 40*lane.
//    - At t+1: spawn_pulse = 1 and spawn_id = granted index.
//    - After a grant: rr pointer = granted index + 1 (mod N); lane counter += 1 (2-bit wrap).
//    - No READY slot: the request is dropped; pointers unchanged; no pulse.
//  - ACTIVE slot on frame_tick:
//    - Retire the slot to COOLDOWN (cnt = 0, slot_valid = 0 next cycle) if either holds:
//      - hit[i] = 1, or
//      - the current x < 3, x >= 640, or y >= 480 - STEP.
//    - Otherwise x -= STEP, y += STEP. 10-bit unsigned arithmetic; the border check
//      retires the slot before any wrap can occur.
//    - hit and border on the same tick: a single retirement.
//  - COOLDOWN slot on frame_tick: cnt += 1. When cnt reaches COOLDOWN-1, go to READY on that tick.
//  - hit[i] on a READY or COOLDOWN slot is ignored; hit outside a frame_tick is ignored.
//  - frame_tick and spawn_tick in the same cycle:
//    - both actions are taken;
//    - a slot whose COOLDOWN expires on that tick is not grantable until the next cycle.
//  - Inactive slots hold their last x/y; consumers must gate on slot_valid.
// CONFIGURATION
//  - DRAGON_KILL_CNT_EN defined: adds output kill_cnt [15:0].
//    - Increments by the number of hit-caused retirements on each frame_tick.
//    - Border retirements are not counted. Saturates at 16'hFFFF. Reset value 0.
//  - DRAGON_KILL_CNT_EN undefined: no port, no counter logic.
// STRUCTURE
//  - Package dragon_pkg:
//    - slot_state_t enum {S_READY, S_ACTIVE, S_COOLDOWN};
//    - SCREEN_W = 640, SCREEN_H = 480, BORDER_MARGIN = 3, LANE_PITCH = 40.
//  - Sub-module dragon_slot (one per slot, generate loop):
//    - holds the state, x/y and cooldown counter;
//    - inputs: grant, spawn_y, frame_tick, hit;
//    - outputs: valid, x, y, ready, killed_by_hit.
//  - Top level: round-robin arbiter, lane counter, spawn_pulse/spawn_id registers, optional kill counter.
// TESTING
//  - Reset, then spawn_tick -> next cycle spawn_pulse=1, spawn_id=0, slot_valid=0001, x0=560, y0=60.
//  - Four spawn_ticks -> slot ids 0,1,2,3; y = 60,100,140,180.
//    A fifth spawn_tick -> no spawn_pulse, state unchanged.
//  - Slot 0 active, 10 frame_ticks -> x0=540, y0=80.
//    Then hit=0001 with frame_tick -> slot_valid[0]=0 on the next cycle.
//  - Retired slot -> stays non-grantable for 99 frame_ticks; grantable after the 100th.
//  - hit and border on the same tick, DRAGON_KILL_CNT_EN defined -> one retirement, kill_cnt += 1.
//    Border only -> kill_cnt unchanged.
//  - rst low mid-flight with 3 slots active -> all slot_valid=0, x/y=0, rr=0.
//    The next spawn_tick grants slot 0 at lane 0 (y=60).

Source files
------------

// File: rtl/dragon_pkg.sv
// -----------------------------------------------------------------------------
// dragon_pkg
//   Shared types and screen constants for the dragon spawn scheduler.
//   slot_state_t : per-slot lifecycle READY -> ACTIVE -> COOLDOWN
//   COORD_W      : width of one x or y coordinate
//   SCREEN_W/H   : visible area in pixels
//   BORDER_MARGIN: x below this retires the sprite before it can wrap
//   LANE_PITCH   : vertical spacing between spawn lanes
// -----------------------------------------------------------------------------
package dragon_pkg;

   typedef enum logic [1:0] {
      S_READY,
      S_ACTIVE,
      S_COOLDOWN
   } slot_state_t;

   localparam int COORD_W       = 10;
   localparam int SCREEN_W      = 640;
   localparam int SCREEN_H      = 480;
   localparam int BORDER_MARGIN = 3;
   localparam int LANE_PITCH    = 40;

endpackage

// File: rtl/dragon_slot.sv
// -----------------------------------------------------------------------------
// dragon_slot
//   One dragon slot: lifecycle state, sprite position and cooldown counter.
//   Ports:
//     clk_22        in   system clock
//     rst           in   asynchronous active-low reset
//     grant         in   spawn this slot (only asserted while ready)
//     spawn_y       in   lane y position loaded on grant
//     frame_tick    in   advance position / cooldown
//     hit           in   kill request, honoured only on frame_tick while ACTIVE
//     valid         out  slot is ACTIVE
//     x, y          out  current (or last) sprite position
//     ready         out  slot is READY and may be granted
//     killed_by_hit out  this frame_tick retires the slot because of hit
// -----------------------------------------------------------------------------
module dragon_slot
   import dragon_pkg::*;
#(
   parameter int COOLDOWN = 100,
   parameter int STEP     = 2,
   parameter int START_X  = 560
) (
   input  logic               clk_22,
   input  logic               rst,
   input  logic               grant,
   input  logic [COORD_W-1:0] spawn_y,
   input  logic               frame_tick,
   input  logic               hit,
   output logic               valid,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               ready,
   output logic               killed_by_hit
);

   localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   slot_state_t        state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               border;

   // Checked on the current position, so a sprite is retired before the
   // next step could wrap the 10-bit coordinates.
   assign border = (x_q <  COORD_W'(BORDER_MARGIN)) ||
                   (x_q >= COORD_W'(SCREEN_W))      ||
                   (y_q >= COORD_W'(SCREEN_H - STEP));

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      cnt_d         = cnt_q;
      killed_by_hit = 1'b0;
      case (state_q)
         S_READY: begin
            if (grant) begin
               state_d = S_ACTIVE;
               x_d     = COORD_W'(START_X);
               y_d     = spawn_y;
            end
         end
         S_ACTIVE: begin
            if (frame_tick) begin
               if (hit || border) begin
                  state_d       = S_COOLDOWN;
                  cnt_d         = '0;
                  killed_by_hit = hit;
               end else begin
                  x_d = x_q - COORD_W'(STEP);
                  y_d = y_q + COORD_W'(STEP);
               end
            end
         end
         S_COOLDOWN: begin
            // cnt counts ticks already spent; the tick seen with
            // cnt == COOLDOWN-1 is the COOLDOWN-th one.
            if (frame_tick) begin
               if (cnt_q == CNT_W'(COOLDOWN - 1)) begin
                  state_d = S_READY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_READY;
      endcase
   end

   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) begin
         state_q <= S_READY;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid = (state_q == S_ACTIVE);
   assign ready = (state_q == S_READY);
   assign x     = x_q;
   assign y     = y_q;

endmodule

// File: rtl/dragon_spawn_sched.sv
// -----------------------------------------------------------------------------
// dragon_spawn_sched
//   Owns NUM_SLOTS dragon slots, grants at most one spawn per spawn_tick
//   round-robin among READY slots, and steps/retires active dragons on
//   frame_tick. Feeds the VGA sprite renderer.
//   Ports:
//     clk_22      in   system clock
//     rst         in   asynchronous active-low reset
//     frame_tick  in   1-cycle pulse: advance positions and cooldowns
//     spawn_tick  in   1-cycle pulse: request one spawn
//     hit         in   per-slot kill request, sampled on frame_tick
//     slot_valid  out  per-slot ACTIVE flag (renderer show-enable)
//     slot_x      out  packed x, slot i at [10i+9:10i]
//     slot_y      out  packed y, same packing
//     spawn_pulse out  1 cycle high when a spawn is granted
//     spawn_id    out  granted slot index, valid with spawn_pulse
//     kill_cnt    out  saturating count of hit retirements
//                      (present only when DRAGON_KILL_CNT_EN is defined)
//   Configuration macro: DRAGON_KILL_CNT_EN
// -----------------------------------------------------------------------------
module dragon_spawn_sched
   import dragon_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int COOLDOWN  = 100,
   parameter int STEP      = 2,
   parameter int START_X   = 560,
   parameter int START_Y   = 60,
   localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
   input  logic                         clk_22,
   input  logic                         rst,
   input  logic                         frame_tick,
   input  logic                         spawn_tick,
   input  logic [NUM_SLOTS-1:0]         hit,
   output logic [NUM_SLOTS-1:0]         slot_valid,
   output logic [COORD_W*NUM_SLOTS-1:0] slot_x,
   output logic [COORD_W*NUM_SLOTS-1:0] slot_y,
   output logic                         spawn_pulse,
   output logic [IDX_W-1:0]             spawn_id
`ifdef DRAGON_KILL_CNT_EN
   ,
   output logic [15:0]                  kill_cnt
`endif
);

   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [1:0]         lane_q, lane_d;
   logic               spawn_pulse_q, spawn_pulse_d;
   logic [IDX_W-1:0]   spawn_id_q, spawn_id_d;

   logic [NUM_SLOTS-1:0] slot_ready;
   logic [NUM_SLOTS-1:0] killed_w;
   logic [NUM_SLOTS-1:0] grant_vec;
   logic [COORD_W-1:0]   x_w [NUM_SLOTS];
   logic [COORD_W-1:0]   y_w [NUM_SLOTS];
   logic [COORD_W-1:0]   spawn_y;

   logic                 found;
   logic [IDX_W-1:0]     grant_idx;
   logic [IDX_W-1:0]     cand;

   assign spawn_y = COORD_W'(START_Y + LANE_PITCH * int'(lane_q));

   // Round-robin scan starting at rr_q; NUM_SLOTS is a power of two so the
   // IDX_W-bit sum wraps naturally.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         cand = rr_q + IDX_W'(k);
         if (!found && slot_ready[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      grant_vec     = '0;
      rr_d          = rr_q;
      lane_d        = lane_q;
      spawn_pulse_d = 1'b0;
      spawn_id_d    = spawn_id_q;
      if (spawn_tick && found) begin
         grant_vec[grant_idx] = 1'b1;
         rr_d                 = grant_idx + 1'b1;
         lane_d               = lane_q + 1'b1;
         spawn_pulse_d        = 1'b1;
         spawn_id_d           = grant_idx;
      end
   end

   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) begin
         rr_q          <= '0;
         lane_q        <= '0;
         spawn_pulse_q <= 1'b0;
         spawn_id_q    <= '0;
      end else begin
         rr_q          <= rr_d;
         lane_q        <= lane_d;
         spawn_pulse_q <= spawn_pulse_d;
         spawn_id_q    <= spawn_id_d;
      end
   end

   assign spawn_pulse = spawn_pulse_q;
   assign spawn_id    = spawn_id_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         dragon_slot #(
            .COOLDOWN (COOLDOWN),
            .STEP     (STEP),
            .START_X  (START_X)
         ) u_slot (
            .clk_22        (clk_22),
            .rst           (rst),
            .grant         (grant_vec[gi]),
            .spawn_y       (spawn_y),
            .frame_tick    (frame_tick),
            .hit           (hit[gi]),
            .valid         (slot_valid[gi]),
            .x             (x_w[gi]),
            .y             (y_w[gi]),
            .ready         (slot_ready[gi]),
            .killed_by_hit (killed_w[gi])
         );
         assign slot_x[COORD_W*gi +: COORD_W] = x_w[gi];
         assign slot_y[COORD_W*gi +: COORD_W] = y_w[gi];
      end
   endgenerate

`ifdef DRAGON_KILL_CNT_EN
   logic [15:0] kill_cnt_q, kill_cnt_d;
   logic [16:0] kill_sum;
   logic [16:0] kill_total;

   // killed_w is only ever set on a frame_tick, so no extra gating is needed.
   always_comb begin
      kill_sum = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         kill_sum = kill_sum + 17'(killed_w[k]);
      end
      kill_total = {1'b0, kill_cnt_q} + kill_sum;
      kill_cnt_d = kill_total[16] ? 16'hFFFF : kill_total[15:0];
   end

   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) begin
         kill_cnt_q <= '0;
      end else begin
         kill_cnt_q <= kill_cnt_d;
      end
   end

   assign kill_cnt = kill_cnt_q;
`else
   logic kill_unused;
   assign kill_unused = |killed_w;
`endif

endmodule

// File: tb/tb_dragon_spawn_sched.sv
// -----------------------------------------------------------------------------
// tb_dragon_spawn_sched
//   Directed self-checking bench for dragon_spawn_sched. Expected spawns are
//   queued when spawn_tick is driven and checked when spawn_pulse appears.
//   Kill counter checks are active when DRAGON_KILL_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dragon_spawn_sched;

   localparam int N       = 4;
   localparam int START_X = 560;

   logic              clk_22     = 1'b0;
   logic              rst        = 1'b0;
   logic              frame_tick = 1'b0;
   logic              spawn_tick = 1'b0;
   logic [N-1:0]      hit        = '0;
   logic [N-1:0]      slot_valid;
   logic [10*N-1:0]   slot_x;
   logic [10*N-1:0]   slot_y;
   logic              spawn_pulse;
   logic [1:0]        spawn_id;
`ifdef DRAGON_KILL_CNT_EN
   logic [15:0]       kill_cnt;
`endif

   typedef struct {
      int id;
      int x;
      int y;
   } spawn_exp_t;

   spawn_exp_t sb_q[$];
   int n_cmp = 0;
   int n_err = 0;

   dragon_spawn_sched dut (
      .clk_22      (clk_22),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .spawn_tick  (spawn_tick),
      .hit         (hit),
      .slot_valid  (slot_valid),
      .slot_x      (slot_x),
      .slot_y      (slot_y),
      .spawn_pulse (spawn_pulse),
      .spawn_id    (spawn_id)
`ifdef DRAGON_KILL_CNT_EN
      ,
      .kill_cnt    (kill_cnt)
`endif
   );

   always #5 clk_22 = ~clk_22;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at a falling edge; return at the next falling
   // edge, where the registered response of that cycle is visible.
   task automatic step(input logic f, input logic s, input logic [N-1:0] h);
      @(negedge clk_22);
      frame_tick = f;
      spawn_tick = s;
      hit        = h;
      @(negedge clk_22);
      frame_tick = 1'b0;
      spawn_tick = 1'b0;
      hit        = '0;
   endtask

   task automatic frames(input int n);
      repeat (n) step(1'b1, 1'b0, '0);
   endtask

   task automatic spawn(input logic f, input logic [N-1:0] h, input bit exp_grant,
                        input int id, input int y);
      spawn_exp_t e;
      if (exp_grant) begin
         e.id = id;
         e.x  = START_X;
         e.y  = y;
         sb_q.push_back(e);
      end
      step(f, 1'b1, h);
      chk("spawn_pulse", 32'(spawn_pulse), 32'(exp_grant));
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (spawn_pulse) begin
            chk("spawn_id", 32'(spawn_id), e.id);
            chk("spawn_valid", 32'(slot_valid[e.id]), 1);
            chk("spawn_x", 32'(slot_x[10*e.id +: 10]), e.x);
            chk("spawn_y", 32'(slot_y[10*e.id +: 10]), e.y);
         end
      end
      $display("spawn: grant=%0b id=%0d valid=%b", spawn_pulse, spawn_id, slot_valid);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk_22);
      chk("rst_valid", 32'(slot_valid), 0);
      chk("rst_x", 32'(slot_x), 0);
      chk("rst_y", 32'(slot_y), 0);
      chk("rst_pulse", 32'(spawn_pulse), 0);
      chk("rst_id", 32'(spawn_id), 0);
`ifdef DRAGON_KILL_CNT_EN
      chk("rst_kill", 32'(kill_cnt), 0);
`endif
      rst = 1'b1;

      // First spawn: slot 0, lane 0
      spawn(1'b0, '0, 1'b1, 0, 60);
      chk("valid_first", 32'(slot_valid), 32'b0001);
      step(1'b0, 1'b0, '0);
      chk("pulse_one_cycle", 32'(spawn_pulse), 0);

      // Fill remaining slots, lanes 1..3
      spawn(1'b0, '0, 1'b1, 1, 100);
      spawn(1'b0, '0, 1'b1, 2, 140);
      spawn(1'b0, '0, 1'b1, 3, 180);
      chk("valid_full", 32'(slot_valid), 32'b1111);

      // No READY slot: request dropped
      spawn(1'b0, '0, 1'b0, 0, 0);
      chk("valid_after_drop", 32'(slot_valid), 32'b1111);

      // Ten steps of motion
      frames(10);
      chk("x0_10", 32'(slot_x[9:0]), 540);
      chk("y0_10", 32'(slot_y[9:0]), 80);
      chk("y3_10", 32'(slot_y[39:30]), 200);
      $display("move: x0=%0d y0=%0d", slot_x[9:0], slot_y[9:0]);

      // hit without frame_tick is ignored
      step(1'b0, 1'b0, 4'b0010);
      chk("hit_no_frame", 32'(slot_valid), 32'b1111);
      chk("x1_hold", 32'(slot_x[19:10]), 540);

      // Kill slot 0
      step(1'b1, 1'b0, 4'b0001);
      chk("valid_after_hit", 32'(slot_valid), 32'b1110);
      chk("x0_held", 32'(slot_x[9:0]), 540);
      chk("x1_moved", 32'(slot_x[19:10]), 538);
`ifdef DRAGON_KILL_CNT_EN
      chk("kill_after_hit", 32'(kill_cnt), 1);
`endif

      // Cooldown: 99 ticks (one carries a hit on the cooling slot)
      frames(49);
      step(1'b1, 1'b0, 4'b0001);
      frames(49);
      spawn(1'b0, '0, 1'b0, 0, 0);
`ifdef DRAGON_KILL_CNT_EN
      chk("kill_cooldown_hit", 32'(kill_cnt), 1);
`endif
      // 100th tick together with spawn_tick: not yet grantable
      spawn(1'b1, '0, 1'b0, 0, 0);
      // Now READY: rr wrapped to 0, lane wrapped to 0
      spawn(1'b0, '0, 1'b1, 0, 60);
      chk("valid_regrant", 32'(slot_valid), 32'b1111);
      chk("x1_long", 32'(slot_x[19:10]), 338);
      chk("y1_long", 32'(slot_y[19:10]), 322);

      // Asynchronous reset mid-flight
      @(negedge clk_22);
      rst = 1'b0;
      #1;
      chk("midrst_valid", 32'(slot_valid), 0);
      chk("midrst_x", 32'(slot_x), 0);
      chk("midrst_y", 32'(slot_y), 0);
`ifdef DRAGON_KILL_CNT_EN
      chk("midrst_kill", 32'(kill_cnt), 0);
`endif
      @(negedge clk_22);
      rst = 1'b1;
      spawn(1'b0, '0, 1'b1, 0, 60);
      spawn(1'b0, '0, 1'b1, 1, 100);

      // Slot 1 reaches y = 478 after 189 steps
      frames(189);
      chk("valid_pre_border", 32'(slot_valid), 32'b0011);
      chk("y1_border", 32'(slot_y[19:10]), 478);
      // hit and border together: one retirement
      step(1'b1, 1'b0, 4'b0010);
      chk("valid_hit_border", 32'(slot_valid), 32'b0001);
      chk("y1_held", 32'(slot_y[19:10]), 478);
`ifdef DRAGON_KILL_CNT_EN
      chk("kill_hit_border", 32'(kill_cnt), 1);
`endif
      // Slot 0 border-only retirement
      frames(19);
      chk("y0_border", 32'(slot_y[9:0]), 478);
      chk("valid_pre_border0", 32'(slot_valid), 32'b0001);
      step(1'b1, 1'b0, '0);
      chk("valid_border_only", 32'(slot_valid), 0);
`ifdef DRAGON_KILL_CNT_EN
      chk("kill_border_only", 32'(kill_cnt), 1);
`endif
      $display("border: valid=%b y0=%0d y1=%0d", slot_valid, slot_y[9:0], slot_y[19:10]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
